// File: rtl/cpu6502_lite.sv
// cpu6502_lite: compact 8-bit CPU that uses the 6502 bus and opcode encoding.
// It runs a subset of the NMOS 6502 instructions with binary arithmetic only.
// Opcodes outside the subset execute as 1-byte, 2-cycle NOPs.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset
//   AB       address bus; the byte at AB is returned on DI one cycle later
//   DI       read data from a registered RAM
//   DO, WE   write data and write enable; memory writes on an edge with RDY=1
//   IRQ, NMI sampled only, with no effect in this revision
//   RDY      0 freezes every register; AB/DO/WE hold their last driven value
module cpu6502_lite #(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] AB,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        WE,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        RDY
);

  typedef enum logic [3:0] {RST0, RST1, RST2, FETCH, DECODE, OPER1, OPER2, READ, WRITE} state_t;
  typedef enum logic [2:0] {M_IMP, M_IMM, M_ZP, M_ABS, M_BR, M_JMP} mode_t;
  typedef enum logic [4:0] {
    O_NOP, O_LDA, O_LDX, O_LDY, O_STA, O_STX, O_STY, O_ADC, O_SBC, O_AND,
    O_ORA, O_EOR, O_CMP, O_INX, O_INY, O_DEX, O_DEY, O_TAX, O_TXA, O_TAY,
    O_TYA, O_CLC, O_SEC, O_BEQ, O_BNE, O_BCC, O_BCS, O_BMI, O_BPL
  } op_t;

  state_t      state, state_nx;
  logic [7:0]  a, x, y, ir, lo;
  logic [7:0]  a_nx, x_nx, y_nx, ir_nx, lo_nx;
  logic        n_f, v_f, z_f, c_f, n_nx, v_nx, z_nx, c_nx;
  logic [15:0] pc, PC_temp, ea, pc_nx, PC_temp_nx, ea_nx;
  logic [15:0] ab_c, ab_q;
  logic [7:0]  do_c, do_q;
  logic        we_c, we_q;

  logic [7:0]        opc, dec_w, sd;
  logic signed [7:0] rel;
  mode_t             mode;
  op_t               op;
  logic              is_store, taken, do_exec;
  logic              unused_ok;

  assign unused_ok = IRQ ^ NMI;

  function automatic logic [7:0] dec(input logic [7:0] o);
    case (o)
      8'hA9: dec = {M_IMM, O_LDA};  8'hA5: dec = {M_ZP, O_LDA};  8'hAD: dec = {M_ABS, O_LDA};
      8'hA2: dec = {M_IMM, O_LDX};  8'hA6: dec = {M_ZP, O_LDX};  8'hAE: dec = {M_ABS, O_LDX};
      8'hA0: dec = {M_IMM, O_LDY};  8'hA4: dec = {M_ZP, O_LDY};  8'hAC: dec = {M_ABS, O_LDY};
      8'h85: dec = {M_ZP, O_STA};   8'h8D: dec = {M_ABS, O_STA};
      8'h86: dec = {M_ZP, O_STX};   8'h8E: dec = {M_ABS, O_STX};
      8'h84: dec = {M_ZP, O_STY};   8'h8C: dec = {M_ABS, O_STY};
      8'h69: dec = {M_IMM, O_ADC};  8'h65: dec = {M_ZP, O_ADC};  8'h6D: dec = {M_ABS, O_ADC};
      8'hE9: dec = {M_IMM, O_SBC};  8'hE5: dec = {M_ZP, O_SBC};  8'hED: dec = {M_ABS, O_SBC};
      8'h29: dec = {M_IMM, O_AND};  8'h25: dec = {M_ZP, O_AND};  8'h2D: dec = {M_ABS, O_AND};
      8'h09: dec = {M_IMM, O_ORA};  8'h05: dec = {M_ZP, O_ORA};  8'h0D: dec = {M_ABS, O_ORA};
      8'h49: dec = {M_IMM, O_EOR};  8'h45: dec = {M_ZP, O_EOR};  8'h4D: dec = {M_ABS, O_EOR};
      8'hC9: dec = {M_IMM, O_CMP};  8'hC5: dec = {M_ZP, O_CMP};  8'hCD: dec = {M_ABS, O_CMP};
      8'hE8: dec = {M_IMP, O_INX};  8'hC8: dec = {M_IMP, O_INY};
      8'hCA: dec = {M_IMP, O_DEX};  8'h88: dec = {M_IMP, O_DEY};
      8'hAA: dec = {M_IMP, O_TAX};  8'h8A: dec = {M_IMP, O_TXA};
      8'hA8: dec = {M_IMP, O_TAY};  8'h98: dec = {M_IMP, O_TYA};
      8'h18: dec = {M_IMP, O_CLC};  8'h38: dec = {M_IMP, O_SEC};
      8'h4C: dec = {M_JMP, O_NOP};
      8'hF0: dec = {M_BR, O_BEQ};   8'hD0: dec = {M_BR, O_BNE};
      8'h90: dec = {M_BR, O_BCC};   8'hB0: dec = {M_BR, O_BCS};
      8'h30: dec = {M_BR, O_BMI};   8'h10: dec = {M_BR, O_BPL};
      default: dec = {M_IMP, O_NOP};
    endcase
  endfunction

  // 8-bit add with carry-in; bit 8 is the carry-out
  function automatic logic [8:0] add8(input logic [7:0] p, input logic [7:0] q, input logic ci);
    add8 = {1'b0, p} + {1'b0, q} + {8'd0, ci};
  endfunction

  // The opcode is still on DI during DECODE; IR holds it afterwards
  always_comb begin
    opc      = (state == DECODE) ? DI : ir;
    dec_w    = dec(opc);
    mode     = mode_t'(dec_w[7:5]);
    op       = op_t'(dec_w[4:0]);
    is_store = (op == O_STA) || (op == O_STX) || (op == O_STY);
    case (op)
      O_STX:   sd = x;
      O_STY:   sd = y;
      default: sd = a;
    endcase
    case (op)
      O_BEQ:   taken = z_f;
      O_BNE:   taken = !z_f;
      O_BCC:   taken = !c_f;
      O_BCS:   taken = c_f;
      O_BMI:   taken = n_f;
      O_BPL:   taken = !n_f;
      default: taken = 1'b0;
    endcase
    do_exec = ((state == DECODE) && (mode == M_IMP)) ||
              ((state == OPER1) && (mode == M_IMM)) || (state == READ);
  end

  assign rel = DI;

  // Execute: register/flag updates from implied, immediate and memory operands
  always_comb begin
    logic [8:0] sum;
    logic [7:0] res;
    logic       set_nz;
    a_nx = a;  x_nx = x;  y_nx = y;
    n_nx = n_f;  v_nx = v_f;  z_nx = z_f;  c_nx = c_f;
    sum = 9'd0;  res = 8'd0;  set_nz = 1'b0;
    if (do_exec) begin
      case (op)
        O_LDA: begin a_nx = DI; res = DI; set_nz = 1'b1; end
        O_LDX: begin x_nx = DI; res = DI; set_nz = 1'b1; end
        O_LDY: begin y_nx = DI; res = DI; set_nz = 1'b1; end
        O_ADC: begin
          sum = add8(a, DI, c_f);
          a_nx = sum[7:0]; res = sum[7:0]; c_nx = sum[8]; set_nz = 1'b1;
          v_nx = (a[7] == DI[7]) && (sum[7] != a[7]);
        end
        O_SBC: begin
          sum = add8(a, ~DI, c_f);
          a_nx = sum[7:0]; res = sum[7:0]; c_nx = sum[8]; set_nz = 1'b1;
          v_nx = (a[7] != DI[7]) && (sum[7] != a[7]);
        end
        O_CMP: begin sum = add8(a, ~DI, 1'b1); res = sum[7:0]; c_nx = sum[8]; set_nz = 1'b1; end
        O_AND: begin a_nx = a & DI; res = a & DI; set_nz = 1'b1; end
        O_ORA: begin a_nx = a | DI; res = a | DI; set_nz = 1'b1; end
        O_EOR: begin a_nx = a ^ DI; res = a ^ DI; set_nz = 1'b1; end
        O_INX: begin x_nx = x + 8'd1; res = x + 8'd1; set_nz = 1'b1; end
        O_INY: begin y_nx = y + 8'd1; res = y + 8'd1; set_nz = 1'b1; end
        O_DEX: begin x_nx = x - 8'd1; res = x - 8'd1; set_nz = 1'b1; end
        O_DEY: begin y_nx = y - 8'd1; res = y - 8'd1; set_nz = 1'b1; end
        O_TAX: begin x_nx = a; res = a; set_nz = 1'b1; end
        O_TXA: begin a_nx = x; res = x; set_nz = 1'b1; end
        O_TAY: begin y_nx = a; res = a; set_nz = 1'b1; end
        O_TYA: begin a_nx = y; res = y; set_nz = 1'b1; end
        O_CLC: c_nx = 1'b0;
        O_SEC: c_nx = 1'b1;
        default: ;
      endcase
    end
    if (set_nz) begin
      n_nx = res[7];
      z_nx = (res == 8'h00);
    end
  end

  // Sequencer: next state, address bus and write strobe
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    PC_temp_nx = PC_temp;
    ir_nx      = ir;
    lo_nx      = lo;
    ea_nx      = ea;
    ab_c       = PC_temp;
    do_c       = 8'h00;
    we_c       = 1'b0;
    case (state)
      RST0: begin ab_c = RESET_VEC; state_nx = RST1; end
      RST1: begin ab_c = RESET_VEC + 16'd1; lo_nx = DI; state_nx = RST2; end
      RST2: begin ab_c = RESET_VEC + 16'd1; pc_nx = {DI, lo}; state_nx = FETCH; end
      FETCH: begin ab_c = pc; PC_temp_nx = pc + 16'd1; state_nx = DECODE; end
      DECODE: begin
        ir_nx      = DI;
        PC_temp_nx = PC_temp + 16'd1;
        if (mode == M_IMP) begin
          pc_nx    = PC_temp;
          state_nx = FETCH;
        end else begin
          state_nx = OPER1;
        end
      end
      OPER1: begin
        case (mode)
          M_IMM: begin pc_nx = PC_temp; state_nx = FETCH; end
          // PC_temp already points past the offset byte
          M_BR: begin
            pc_nx    = taken ? PC_temp + {{8{rel[7]}}, rel} : PC_temp;
            state_nx = FETCH;
          end
          M_ZP: begin
            ab_c     = {8'h00, DI};
            ea_nx    = {8'h00, DI};
            state_nx = is_store ? WRITE : READ;
          end
          M_ABS, M_JMP: begin
            lo_nx      = DI;
            PC_temp_nx = PC_temp + 16'd1;
            state_nx   = OPER2;
          end
          default: state_nx = FETCH;
        endcase
      end
      OPER2: begin
        if (mode == M_JMP) begin
          pc_nx    = {DI, lo};
          state_nx = FETCH;
        end else begin
          ab_c     = {DI, lo};
          ea_nx    = {DI, lo};
          state_nx = is_store ? WRITE : READ;
        end
      end
      READ: begin ab_c = ea; pc_nx = PC_temp; state_nx = FETCH; end
      WRITE: begin
        ab_c     = ea;
        we_c     = 1'b1;
        do_c     = sd;
        pc_nx    = PC_temp;
        state_nx = FETCH;
      end
      default: state_nx = RST0;
    endcase
  end

  // While stalled, DI may be garbage; the bus shows the last value driven with RDY=1
  assign AB = RDY ? ab_c : ab_q;
  assign DO = RDY ? do_c : do_q;
  assign WE = RDY ? we_c : we_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RST0;
      a       <= 8'h00;
      x       <= 8'h00;
      y       <= 8'h00;
      n_f     <= 1'b0;
      v_f     <= 1'b0;
      z_f     <= 1'b0;
      c_f     <= 1'b0;
      pc      <= 16'h0000;
      PC_temp <= 16'h0000;
      ir      <= 8'h00;
      lo      <= 8'h00;
      ea      <= 16'h0000;
      ab_q    <= RESET_VEC;
      do_q    <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      ab_q <= AB;
      do_q <= DO;
      we_q <= WE;
      if (RDY) begin
        state   <= state_nx;
        a       <= a_nx;
        x       <= x_nx;
        y       <= y_nx;
        n_f     <= n_nx;
        v_f     <= v_nx;
        z_f     <= z_nx;
        c_f     <= c_nx;
        pc      <= pc_nx;
        PC_temp <= PC_temp_nx;
        ir      <= ir_nx;
        lo      <= lo_nx;
        ea      <= ea_nx;
      end
    end
  end

endmodule

// File: tb/tb_cpu6502_lite.sv
// Directed bench for cpu6502_lite with a registered, RDY-gated 64 KiB RAM.
module tb_cpu6502_lite;

  localparam int S_RST0 = 0, S_RST1 = 1, S_FETCH = 3, S_DECODE = 4, S_WRITE = 8;

  logic        clk = 1'b0;
  logic        reset_n, RDY, IRQ, NMI, WE;
  logic [15:0] AB;
  logic [7:0]  DI, DO;
  logic [7:0]  mem [0:65535];
  logic [7:0]  ram_q;
  logic        xmode;
  logic        ld_en;
  logic [15:0] ld_addr, pa;
  logic [7:0]  ld_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  cpu6502_lite dut (
    .clk(clk), .reset_n(reset_n), .AB(AB), .DI(DI), .DO(DO), .WE(WE),
    .IRQ(IRQ), .NMI(NMI), .RDY(RDY)
  );

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (RDY) begin
      if (WE) mem[AB] <= DO;
      ram_q <= mem[AB];
    end
  end

  assign DI = (xmode && !RDY) ? 8'hxx : ram_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic [15:0] ad, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = ad; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic emit(input logic [7:0] d);
    poke(pa, d);
    pa = pa + 16'd1;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0; RDY = 1'b1; xmode = 1'b0;
    @(negedge clk);
    poke(16'hFFFC, 8'h00);
    poke(16'hFFFD, 8'h04);
    pa = 16'h0400;
  endtask

  task automatic load_arith();
    poke(16'h0200, 8'h00);
    pa = 16'h0400;
    emit(8'hA9); emit(8'h7F);               // LDA #$7F
    emit(8'h69); emit(8'h01);               // ADC #$01
    emit(8'h8D); emit(8'h00); emit(8'h02);  // STA $0200
    emit(8'h4C); emit(8'h07); emit(8'h04);  // JMP $0407
  endtask

  function automatic logic [3:0] flags();
    flags = {dut.n_f, dut.v_f, dut.z_f, dut.c_f};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int we_cnt, bad_ab, bad_pc, bad_di, dec_n, dex_n;
    logic [15:0] prev_ab, we_ab;
    logic        prev_we, found, fell, done;
    logic [7:0]  x_at;

    IRQ = 1'b0; NMI = 1'b0; ld_en = 1'b0; ld_addr = 16'h0; ld_data = 8'h0;
    xmode = 1'b0; RDY = 1'b1; reset_n = 1'b1; pa = 16'h0400;
    #2 reset_n = 1'b0;
    tick(2);

    // Reset state
    chk("rst_ab", 32'(AB), 32'hFFFC);
    chk("rst_we", 32'(WE), 0);
    chk("rst_do", 32'(DO), 0);
    chk("rst_state", 32'(dut.state), S_RST0);
    chk("rst_axy", {8'h0, dut.a, dut.x, dut.y}, 0);
    chk("rst_flags", 32'(flags()), 0);
    chk("rst_pc", {dut.pc, dut.PC_temp}, 0);
    RDY = 1'b0; #1;
    chk("rst_ab_rdy0", 32'(AB), 32'hFFFC);
    RDY = 1'b1;

    // Reset vector and JMP loop
    hold_reset();
    emit(8'h4C); emit(8'h00); emit(8'h04);
    reset_n = 1'b1; #1;
    chk("vec_ab0", 32'(AB), 32'hFFFC);
    tick(1);
    chk("vec_ab1", 32'(AB), 32'hFFFD);
    tick(2);
    chk("fetch0_ab", 32'(AB), 32'h0400);
    chk("fetch0_st", 32'(dut.state), S_FETCH);
    tick(1);
    chk("dec0_pct", 32'(dut.PC_temp), 32'h0401);
    chk("dec0_di", 32'(DI), 32'h4C);
    tick(3);
    chk("fetch1_ab", 32'(AB), 32'h0400);
    tick(1);
    chk("dec1_st", 32'(dut.state), S_DECODE);
    chk("dec1_pct", 32'(dut.PC_temp), 32'h0401);

    // Wait states: RDY high one clock in three, DI garbage while low
    reset_n = 1'b0; #1;
    tick(1);
    xmode = 1'b1; RDY = 1'b0;
    reset_n = 1'b1;
    tick(1);
    chk("wait_rst_hold", 32'(dut.state), S_RST0);
    bad_ab = 0; bad_pc = 0; bad_di = 0; dec_n = 0;
    prev_ab = AB; prev_we = WE;
    for (int c = 0; c < 90; c++) begin
      RDY = (c % 3 == 0); #1;
      if (!RDY && (AB !== prev_ab || WE !== prev_we)) bad_ab++;
      if (RDY && dut.state == S_DECODE) begin
        dec_n++;
        if (dut.PC_temp !== 16'h0401) bad_pc++;
        if (DI !== 8'h4C) bad_di++;
      end
      prev_ab = AB; prev_we = WE;
      @(negedge clk);
    end
    chk("wait_ab_stable", 32'(bad_ab), 0);
    chk("wait_dec_pct", 32'(bad_pc), 0);
    chk("wait_dec_di", 32'(bad_di), 0);
    chk("wait_dec_seen", 32'(dec_n >= 5), 1);
    RDY = 1'b1; xmode = 1'b0;

    // Arithmetic overflow and absolute store
    hold_reset();
    load_arith();
    reset_n = 1'b1;
    we_cnt = 0; we_ab = 16'h0;
    for (int c = 0; c < 40; c++) begin
      if (WE && RDY) begin we_cnt++; we_ab = AB; end
      @(negedge clk);
    end
    chk("adc_we_cnt", 32'(we_cnt), 1);
    chk("adc_we_ab", 32'(we_ab), 32'h0200);
    chk("adc_mem", 32'(mem[16'h0200]), 32'h80);
    chk("adc_a", 32'(dut.a), 32'h80);
    chk("adc_nvzc", 32'(flags()), 32'b1000 | 32'b0100);

    // Logic, SBC, transfers, zp/abs load-store, CMP
    hold_reset();
    poke(16'h0010, 8'h00); poke(16'h0011, 8'hA5); poke(16'h0201, 8'h00);
    pa = 16'h0400;
    emit(8'h38);                            // SEC
    emit(8'hA9); emit(8'h50);               // LDA #$50
    emit(8'hE9); emit(8'hF0);               // SBC #$F0 -> 60, C=0
    emit(8'h85); emit(8'h10);               // STA $10
    emit(8'hA2); emit(8'h0F);               // LDX #$0F
    emit(8'h8A);                            // TXA
    emit(8'h25); emit(8'h10);               // AND $10 -> 00
    emit(8'h05); emit(8'h11);               // ORA $11 -> A5
    emit(8'h49); emit(8'hFF);               // EOR #$FF -> 5A
    emit(8'hA8);                            // TAY
    emit(8'hC8);                            // INY -> 5B
    emit(8'h8C); emit(8'h01); emit(8'h02);  // STY $0201
    emit(8'hAD); emit(8'h01); emit(8'h02);  // LDA $0201
    emit(8'hC9); emit(8'h5B);               // CMP #$5B
    emit(8'h4C); emit(8'h1A); emit(8'h04);  // JMP $041A
    reset_n = 1'b1;
    tick(80);
    chk("mix_zp_sta", 32'(mem[16'h0010]), 32'h60);
    chk("mix_abs_sty", 32'(mem[16'h0201]), 32'h5B);
    chk("mix_a", 32'(dut.a), 32'h5B);
    chk("mix_x", 32'(dut.x), 32'h0F);
    chk("mix_y", 32'(dut.y), 32'h5B);
    chk("mix_nvzc", 32'(flags()), 32'b0011);

    // Backward BNE loop, fall-through, forward BCC
    hold_reset();
    emit(8'hA2); emit(8'h00);               // LDX #$00
    emit(8'hCA);                            // 0402 DEX
    emit(8'hD0); emit(8'hFD);               // 0403 BNE $0402
    emit(8'h18);                            // 0405 CLC
    emit(8'h90); emit(8'h02);               // 0406 BCC $040A
    emit(8'h4C); emit(8'h08); emit(8'h04);  // 0408 trap
    emit(8'h4C); emit(8'h0A); emit(8'h04);  // 040A end
    reset_n = 1'b1;
    dex_n = 0; fell = 1'b0; done = 1'b0; x_at = 8'h55;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (dut.state == S_FETCH) begin
        if (AB == 16'h0402) dex_n++;
        if (AB == 16'h0405 && !fell) begin fell = 1'b1; x_at = dut.x; end
        if (AB == 16'h040A || AB == 16'h0408) done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    chk("br_fell", 32'(fell), 1);
    chk("br_x_at_fall", 32'(x_at), 0);
    chk("br_dex_iters", 32'(dex_n), 256);
    chk("br_bcc_target", 32'(AB), 32'h040A);

    // Asynchronous reset in the middle of a write cycle
    hold_reset();
    load_arith();
    reset_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dut.state == S_WRITE) found = 1'b1;
      else @(negedge clk);
    end
    chk("ar_found_write", 32'(found), 1);
    chk("ar_we_before", 32'(WE), 1);
    reset_n = 1'b0; #1;
    chk("ar_we_async", 32'(WE), 0);
    chk("ar_state_async", 32'(dut.state), S_RST0);
    chk("ar_ab_async", 32'(AB), 32'hFFFC);
    tick(1);
    chk("ar_no_write", 32'(mem[16'h0200]), 32'h00);
    reset_n = 1'b1; #1;
    chk("ar_vec_lo", 32'(AB), 32'hFFFC);
    tick(1);
    chk("ar_vec_hi", 32'(AB), 32'hFFFD);
    chk("ar_st_rst1", 32'(dut.state), S_RST1);
    tick(2);
    chk("ar_refetch", 32'(AB), 32'h0400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
